one_to_n_sync_fifo: RTL and testbench

Width-expanding synchronous FIFO and counterpart to the N-to-1 merging FIFO. A single narrow stream is written one element per cycle, packed into lanes 0..N-1 in arrival order, and stored as N-lane words with a per-lane valid mask. `flush_i` closes a partial word early. It sits where a serialized stream must be fanned back out to N parallel consumers, one lane per consumer.

---
 rtl/fifo_pkg.sv | 14 +
 rtl/one_to_n_packer.sv | 77 +++++++
 rtl/one_to_n_sync_fifo.sv | 85 ++++++++
 tb/tb_one_to_n_sync_fifo.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the 1-to-N and N-to-1 lane FIFOs.
package fifo_pkg;

  // Bits needed to index n entries (at least one bit).
  function automatic int unsigned ptr_w(input int unsigned n);
    return (n > 1) ? int'($clog2(n)) : 1;
  endfunction

  // Bits needed to hold a count of 0..depth inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return int'($clog2(depth + 1));
  endfunction

endpackage

// File: rtl/one_to_n_packer.sv
// Packs a narrow element stream into N-lane words with a lane valid mask.
module one_to_n_packer
  import fifo_pkg::*;
#(
  parameter int unsigned N          = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic [DATA_WIDTH-1:0]        data_i,
  input  logic                         wr_en_i,
  input  logic                         flush_i,
  input  logic                         full_i,
  output logic                         commit_c_o,
  output logic [0:N-1][DATA_WIDTH-1:0] word_c_o,
  output logic [0:N-1]                 mask_c_o,
  output logic                         packing_o
);

  localparam int unsigned LP_W = ptr_w(N);

  typedef enum logic {
    S_IDLE,
    S_FILLING
  } state_e;

  state_e                         state_q;
  logic [LP_W-1:0]                ptr_q;
  logic [0:N-1][DATA_WIDTH-1:0]   accum_q;
  logic [0:N-1]                   mask_q;
  logic [0:N-1][DATA_WIDTH-1:0]   lanes_c;
  logic [0:N-1]                   lmask_c;
  logic                           accept;
  logic                           last_lane;
  logic                           commit;

  assign accept    = wr_en_i & ~full_i;
  assign last_lane = (ptr_q == LP_W'(N - 1));
  // A flush with nothing pending and nothing arriving is a no-op.
  assign commit    = (accept & (last_lane | flush_i))
                   | (flush_i & ~full_i & (mask_q != '0));

  // Word as it will be stored, including an element accepted this cycle.
  always_comb begin
    lanes_c = accum_q;
    lmask_c = mask_q;
    if (accept) begin
      lanes_c[ptr_q] = data_i;
      lmask_c[ptr_q] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      accum_q <= '0;
      mask_q  <= '0;
    end else if (commit) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      accum_q <= '0;
      mask_q  <= '0;
    end else if (accept) begin
      state_q <= S_FILLING;
      ptr_q   <= ptr_q + LP_W'(1);
      accum_q <= lanes_c;
      mask_q  <= lmask_c;
    end
  end

  assign commit_c_o = commit;
  assign word_c_o   = lanes_c;
  assign mask_c_o   = lmask_c;
  assign packing_o  = (state_q == S_FILLING);

endmodule

// File: rtl/one_to_n_sync_fifo.sv
// Width-expanding FIFO: 1-wide writes packed into N-lane words, show-ahead reads.
module one_to_n_sync_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned N          = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic [DATA_WIDTH-1:0]        data_i,
  input  logic                         wr_en_i,
  input  logic                         flush_i,
  output logic                         fifo_full_o,
  output logic                         packing_o,
  input  logic                         rd_en_i,
  output logic [0:N-1][DATA_WIDTH-1:0] data_o,
  output logic [0:N-1]                 valid_o,
  output logic                         fifo_empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);
  localparam int unsigned CNT_W = cnt_w(DEPTH);

  typedef struct packed {
    logic [0:N-1][DATA_WIDTH-1:0] lanes;
    logic [0:N-1]                 mask;
  } word_t;

  word_t                        mem_q [DEPTH];
  logic [PTR_W-1:0]             wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]             count_q;
  logic                         full, empty;
  logic                         push, pop;
  logic [0:N-1][DATA_WIDTH-1:0] pk_word;
  logic [0:N-1]                 pk_mask;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign pop   = rd_en_i & ~empty;

  one_to_n_packer #(
    .N          (N),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_packer (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .data_i     (data_i),
    .wr_en_i    (wr_en_i),
    .flush_i    (flush_i),
    .full_i     (full),
    .commit_c_o (push),
    .word_c_o   (pk_word),
    .mask_c_o   (pk_mask),
    .packing_o  (packing_o)
  );

  // Storage needs no reset: reads are masked to zero while empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{lanes: pk_word, mask: pk_mask};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !push) count_q <= count_q - CNT_W'(1);
    end
  end

  assign fifo_full_o  = full;
  assign fifo_empty_o = empty;
  assign count_o      = count_q;
  assign data_o       = empty ? '0 : mem_q[rd_ptr_q].lanes;
  assign valid_o      = empty ? '0 : mem_q[rd_ptr_q].mask;

endmodule

// File: tb/tb_one_to_n_sync_fifo.sv
// Directed self-checking bench for one_to_n_sync_fifo (N=4, 8-bit lanes, DEPTH=8).
module tb_one_to_n_sync_fifo;

  logic              clk_i = 1'b0;
  logic              rst_n_i;
  logic [7:0]        data_i;
  logic              wr_en_i;
  logic              flush_i;
  logic              fifo_full_o;
  logic              packing_o;
  logic              rd_en_i;
  logic [0:3][7:0]   data_o;
  logic [0:3]        valid_o;
  logic              fifo_empty_o;
  logic [3:0]        count_o;

  int checks   = 0;
  int failures = 0;

  one_to_n_sync_fifo #(.N(4), .DATA_WIDTH(8), .DEPTH(8)) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .data_i       (data_i),
    .wr_en_i      (wr_en_i),
    .flush_i      (flush_i),
    .fifo_full_o  (fifo_full_o),
    .packing_o    (packing_o),
    .rd_en_i      (rd_en_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .fifo_empty_o (fifo_empty_o),
    .count_o      (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    data_i  = d;
    wr_en_i = 1'b1;
    step();
    wr_en_i = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] exp_word, input logic [3:0] exp_mask);
    check({tag, "_data"}, 64'(data_o), 64'(exp_word));
    check({tag, "_valid"}, 64'(valid_o), 64'(exp_mask));
    rd_en_i = 1'b1;
    step();
    rd_en_i = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_full"},    64'(fifo_full_o),  64'(0));
    check({tag, "_packing"}, 64'(packing_o),    64'(0));
    check({tag, "_empty"},   64'(fifo_empty_o), 64'(1));
    check({tag, "_count"},   64'(count_o),      64'(0));
    check({tag, "_data"},    64'(data_o),       64'(0));
    check({tag, "_valid"},   64'(valid_o),      64'(0));
  endtask

  initial begin
    rst_n_i = 1'b0;
    data_i  = '0;
    wr_en_i = 1'b0;
    flush_i = 1'b0;
    rd_en_i = 1'b0;
    #3;
    check_reset_vals("rst");
    #4 rst_n_i = 1'b1;
    step();

    // Full word of four consecutive writes
    wr(8'h11);
    check("pack_first", 64'(packing_o), 64'(1));
    check("empty_first", 64'(fifo_empty_o), 64'(1));
    wr(8'h22); wr(8'h33); wr(8'h44);
    check("w1_count", 64'(count_o), 64'(1));
    check("w1_empty", 64'(fifo_empty_o), 64'(0));
    check("w1_packing", 64'(packing_o), 64'(0));
    pop_chk("w1", 32'h11223344, 4'b1111);
    check("w1_popped_empty", 64'(fifo_empty_o), 64'(1));
    check("w1_popped_data", 64'(data_o), 64'(0));

    // Partial word closed by flush
    wr(8'hA1); wr(8'hA2);
    check("flush_pre_packing", 64'(packing_o), 64'(1));
    flush_i = 1'b1; step(); flush_i = 1'b0;
    check("flush_packing", 64'(packing_o), 64'(0));
    check("flush_count", 64'(count_o), 64'(1));
    pop_chk("flush", 32'hA1A20000, 4'b1100);

    // Write together with flush, then an idle flush
    data_i = 8'hB1; wr_en_i = 1'b1; flush_i = 1'b1;
    step();
    wr_en_i = 1'b0; flush_i = 1'b0;
    check("wf_count", 64'(count_o), 64'(1));
    check("wf_packing", 64'(packing_o), 64'(0));
    flush_i = 1'b1; step(); flush_i = 1'b0;
    check("idle_flush_count", 64'(count_o), 64'(1));
    pop_chk("wf", 32'hB1000000, 4'b1000);
    check("wf_empty", 64'(fifo_empty_o), 64'(1));

    // Fill all eight entries with elements 1..32
    for (int i = 1; i <= 32; i++) wr(8'(i));
    check("fill_full", 64'(fifo_full_o), 64'(1));
    check("fill_count", 64'(count_o), 64'(8));
    wr(8'hFF);
    check("drop_count", 64'(count_o), 64'(8));
    check("drop_packing", 64'(packing_o), 64'(0));
    flush_i = 1'b1; step(); flush_i = 1'b0;
    check("full_flush_count", 64'(count_o), 64'(8));
    pop_chk("full_w1", 32'h01020304, 4'b1111);
    check("pop_unfull", 64'(fifo_full_o), 64'(0));
    check("pop_count", 64'(count_o), 64'(7));
    for (int i = 33; i <= 36; i++) wr(8'(i));
    check("refill_full", 64'(fifo_full_o), 64'(1));
    pop_chk("wrap_w2", 32'h05060708, 4'b1111);
    pop_chk("wrap_w3", 32'h090A0B0C, 4'b1111);
    pop_chk("wrap_w4", 32'h0D0E0F10, 4'b1111);
    pop_chk("wrap_w5", 32'h11121314, 4'b1111);
    pop_chk("wrap_w6", 32'h15161718, 4'b1111);
    pop_chk("wrap_w7", 32'h191A1B1C, 4'b1111);
    pop_chk("wrap_w8", 32'h1D1E1F20, 4'b1111);
    pop_chk("wrap_w9", 32'h21222324, 4'b1111);
    check("wrap_empty", 64'(fifo_empty_o), 64'(1));

    // Commit and pop in the same cycle at count 3
    for (int i = 8'h31; i <= 8'h3C; i++) wr(8'(i));
    wr(8'h41); wr(8'h42); wr(8'h43);
    check("cp_pre_count", 64'(count_o), 64'(3));
    data_i = 8'h44; wr_en_i = 1'b1; rd_en_i = 1'b1;
    step();
    wr_en_i = 1'b0; rd_en_i = 1'b0;
    check("cp_count", 64'(count_o), 64'(3));
    pop_chk("cp_w2", 32'h35363738, 4'b1111);
    pop_chk("cp_w3", 32'h393A3B3C, 4'b1111);
    pop_chk("cp_w4", 32'h41424344, 4'b1111);
    check("cp_empty", 64'(fifo_empty_o), 64'(1));

    // Asynchronous reset mid-word
    for (int i = 8'h51; i <= 8'h58; i++) wr(8'(i));
    wr(8'h61);
    check("ar_pre_count", 64'(count_o), 64'(2));
    check("ar_pre_packing", 64'(packing_o), 64'(1));
    #1 rst_n_i = 1'b0;
    #1;
    check_reset_vals("async_rst");
    #1 rst_n_i = 1'b1;
    step();
    wr(8'h71); wr(8'h72); wr(8'h73); wr(8'h74);
    check("post_rst_count", 64'(count_o), 64'(1));
    pop_chk("post_rst", 32'h71727374, 4'b1111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
